// File: rtl/qroute_pkg.sv
// Shared definitions for the Q-routing node: float16 constants, table layout
// and the neighbour-scan state encoding.
package qroute_pkg;

  localparam int          WORD_WIDTH   = 16;
  localparam int          ENTRY_WORDS  = 3;
  localparam logic [15:0] FP16_POS_INF = 16'h7C00;
  localparam logic [15:0] NO_HOP       = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

  function automatic logic fp16_is_nan(input logic [15:0] v);
    return (v[14:10] == 5'h1F) && (v[9:0] != 10'd0);
  endfunction

endpackage

// File: rtl/fp16_less.sv
// Combinational strict less-than on IEEE half-precision values.
// Any NaN operand gives 0, and -0 compares equal to +0.
module fp16_less
  import qroute_pkg::*;
(
  input  logic [WORD_WIDTH-1:0] a,
  input  logic [WORD_WIDTH-1:0] b,
  output logic                  lt
);

  logic [14:0] a_mag;
  logic [14:0] b_mag;

  always_comb begin
    a_mag = a[14:0];
    b_mag = b[14:0];
    lt    = 1'b0;
    if (fp16_is_nan(a) || fp16_is_nan(b) || (a_mag == 15'd0 && b_mag == 15'd0)) begin
      lt = 1'b0;
    end else if (a[15] && !b[15]) begin
      lt = 1'b1;
    end else if (!a[15] && b[15]) begin
      lt = 1'b0;
    end else if (!a[15]) begin
      lt = (a_mag < b_mag);
    end else begin
      // Both negative: larger magnitude is the smaller value.
      lt = (a_mag > b_mag);
    end
  end

endmodule

// File: rtl/best_neighbor_scan.sv
// Scans the neighbour Q-table (id, q, origin per entry) and reports the
// minimum-Q neighbour plus the Q of the previously used hop, then pulses done.
module best_neighbor_scan #(
  parameter int ADDR_WIDTH    = 10,
  parameter int MAX_NEIGHBORS = 64,
  parameter int WORD_WIDTH    = 16
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] MY_NODE_ID,
  input  logic [WORD_WIDTH-1:0] prev_hop,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [6:0]            neighbor_count,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  output logic [WORD_WIDTH-1:0] best_hop,
  output logic [WORD_WIDTH-1:0] best_value,
  output logic [WORD_WIDTH-1:0] best_origin,
  output logic [WORD_WIDTH-1:0] mybest,
  output logic                  busy,
  output logic                  done
);

  localparam int         CNT_W = 9;
  localparam logic [6:0] MAX_N = 7'(MAX_NEIGHBORS);

  qroute_pkg::scan_state_e state_q;

  logic [6:0]            n_clamped;
  logic [CNT_W-1:0]      issue_cnt_q, last_issue_q;
  logic [WORD_WIDTH-1:0] my_id_q, prev_hop_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  mem_rd_en_q, busy_q, done_q;
  logic                  rvalid_q;
  logic [1:0]            phase_q;
  logic [WORD_WIDTH-1:0] ent_id_q, ent_q_q;
  logic [WORD_WIDTH-1:0] w_hop_q, w_val_q, w_org_q, w_my_q;
  logic                  w_my_found_q;
  logic [WORD_WIDTH-1:0] w_hop_d, w_val_d, w_org_d, w_my_d;
  logic                  w_my_found_d;
  logic [WORD_WIDTH-1:0] best_hop_q, best_value_q, best_origin_q, mybest_q;
  logic                  q_lt;

  assign n_clamped   = (neighbor_count > MAX_N) ? MAX_N : neighbor_count;
  assign mem_addr    = mem_addr_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign best_hop    = best_hop_q;
  assign best_value  = best_value_q;
  assign best_origin = best_origin_q;
  assign mybest      = mybest_q;

  fp16_less u_less (
    .a  (ent_q_q),
    .b  (w_val_q),
    .lt (q_lt)
  );

  // The origin word is evaluated as it arrives, so DRAIN can publish the
  // final entry without waiting an extra cycle.
  always_comb begin
    w_hop_d      = w_hop_q;
    w_val_d      = w_val_q;
    w_org_d      = w_org_q;
    w_my_d       = w_my_q;
    w_my_found_d = w_my_found_q;
    if (rvalid_q && phase_q == 2'd2) begin
      if (ent_id_q != my_id_q && !qroute_pkg::fp16_is_nan(ent_q_q) && q_lt) begin
        w_hop_d = ent_id_q;
        w_val_d = ent_q_q;
        w_org_d = mem_rdata;
      end
      if (ent_id_q == prev_hop_q && !w_my_found_q) begin
        w_my_d       = ent_q_q;
        w_my_found_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q       <= qroute_pkg::ST_IDLE;
      issue_cnt_q   <= '0;
      last_issue_q  <= '0;
      my_id_q       <= '0;
      prev_hop_q    <= '0;
      mem_addr_q    <= '0;
      mem_rd_en_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rvalid_q      <= 1'b0;
      phase_q       <= 2'd0;
      ent_id_q      <= '0;
      ent_q_q       <= '0;
      w_hop_q       <= qroute_pkg::NO_HOP;
      w_val_q       <= qroute_pkg::FP16_POS_INF;
      w_org_q       <= qroute_pkg::NO_HOP;
      w_my_q        <= qroute_pkg::FP16_POS_INF;
      w_my_found_q  <= 1'b0;
      best_hop_q    <= qroute_pkg::NO_HOP;
      best_value_q  <= qroute_pkg::FP16_POS_INF;
      best_origin_q <= qroute_pkg::NO_HOP;
      mybest_q      <= qroute_pkg::FP16_POS_INF;
    end else begin
      rvalid_q     <= mem_rd_en_q;
      w_hop_q      <= w_hop_d;
      w_val_q      <= w_val_d;
      w_org_q      <= w_org_d;
      w_my_q       <= w_my_d;
      w_my_found_q <= w_my_found_d;
      if (rvalid_q) begin
        phase_q <= (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
        if (phase_q == 2'd0) ent_id_q <= mem_rdata;
        if (phase_q == 2'd1) ent_q_q  <= mem_rdata;
      end

      case (state_q)
        qroute_pkg::ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            my_id_q      <= MY_NODE_ID;
            prev_hop_q   <= prev_hop;
            last_issue_q <= CNT_W'(n_clamped) * CNT_W'(qroute_pkg::ENTRY_WORDS) - CNT_W'(1);
            issue_cnt_q  <= '0;
            phase_q      <= 2'd0;
            w_hop_q      <= qroute_pkg::NO_HOP;
            w_val_q      <= qroute_pkg::FP16_POS_INF;
            w_org_q      <= qroute_pkg::NO_HOP;
            w_my_q       <= qroute_pkg::FP16_POS_INF;
            w_my_found_q <= 1'b0;
            busy_q       <= 1'b1;
            if (n_clamped != 7'd0) begin
              mem_addr_q  <= base_addr;
              mem_rd_en_q <= 1'b1;
              state_q     <= qroute_pkg::ST_READ;
            end else begin
              state_q     <= qroute_pkg::ST_DRAIN;
            end
          end
        end
        qroute_pkg::ST_READ: begin
          if (issue_cnt_q == last_issue_q) begin
            mem_rd_en_q <= 1'b0;
            state_q     <= qroute_pkg::ST_DRAIN;
          end else begin
            issue_cnt_q <= issue_cnt_q + CNT_W'(1);
            mem_addr_q  <= mem_addr_q + ADDR_WIDTH'(1);
          end
        end
        qroute_pkg::ST_DRAIN: begin
          best_hop_q    <= w_hop_d;
          best_value_q  <= w_val_d;
          best_origin_q <= w_org_d;
          mybest_q      <= w_my_d;
          done_q        <= 1'b1;
          state_q       <= qroute_pkg::ST_DONE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= qroute_pkg::ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/best_neighbor_scan.md
Name: best_neighbor_scan

Overview:
Upstream producer for the epsilon-greedy next-hop policy stage in the Q-routing node. On `start`, it scans the node's neighbour Q-table in word memory and finds the minimum-Q (best) entry and the Q-value of the previously used hop. It registers `best_hop`, `best_value`, `best_origin` and `mybest`, then pulses `done`, which drives the policy stage's `done_prev` input. Q-values are IEEE half-precision floats; lower is better.

Parameters:
ADDR_WIDTH, 10, word address width of the Q-table memory.
MAX_NEIGHBORS, 64, maximum value accepted on `neighbor_count`; larger values are clamped to this.
WORD_WIDTH, 16, data word width (float16 / node ID).

Ports:
clock  in  1  system clock; all logic is on the rising edge.
nreset  in  1  synchronous, active-low reset.
start  in  1  begin a scan; sampled only in IDLE.
MY_NODE_ID  in  16  this node's ID; entries with this ID are skipped.
prev_hop  in  16  ID whose Q-value is reported on `mybest`.
base_addr  in  ADDR_WIDTH  address of the first table word.
neighbor_count  in  7  number of entries N.
mem_addr  out  ADDR_WIDTH  read address.
mem_rd_en  out  1  read strobe.
mem_rdata  in  16  read data, valid one cycle after `mem_rd_en`.
best_hop  out  16  neighbour ID of the minimum-Q entry.
best_value  out  16  minimum Q (float16).
best_origin  out  16  origin-ID field of the best entry.
mybest  out  16  Q of the entry with ID == `prev_hop`.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle completion pulse.

Behaviour:
- Entry layout: 3 consecutive words per entry: `neighbor_id`, `qvalue`, `origin_id`. Entry k starts at `base_addr` + 3k. Address arithmetic wraps modulo 2^ADDR_WIDTH.
- Reset values:
  - `best_hop` = 16'hFFFF, `best_value` = 16'h7C00 (+inf), `best_origin` = 16'hFFFF, `mybest` = 16'h7C00.
  - `mem_addr` = 0, `mem_rd_en` = 0, `busy` = 0, `done` = 0.
  - State = IDLE.
- Reset mid-scan: all outputs return to reset values on the next edge. No partial result survives.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE:
    - `start` = 1: latch N (clamped), `base_addr`, `prev_hop`, `MY_NODE_ID`; clear the working min to +inf / FFFF; clear working mybest to +inf.
    - Go to READ if N > 0, else go to DRAIN.
  - READ:
    - `mem_rd_en` = 1 every cycle; address increments by 1 per cycle.
    - After 3N issues, go to DRAIN.
  - DRAIN:
    - One cycle; consumes the final returned word.
    - Copies working registers to the outputs.
    - Go to DONE.
  - DONE:
    - `done` = 1 for exactly one cycle.
    - Go to IDLE.
- Capture pipeline: a 2-bit word-phase counter travels with the one-cycle-delayed read-valid.
  - Phase 0 captures the ID.
  - Phase 1 captures Q.
  - Phase 2 captures origin and evaluates the entry.
- Evaluation rules, applied when the entry is complete:
  - Skip the entry if ID == `MY_NODE_ID`, or Q is NaN (exp = 5'h1F and mantissa != 0).
  - Otherwise, if fp16_less(Q, working_min), update working best_hop / value / origin.
  - The comparison is strict: on ties the first entry in table order wins.
  - If ID == `prev_hop` and this is the first such match, set working mybest = Q.
  - A NaN Q for `prev_hop` is still reported.
- fp16_less rules:
  - Sign-magnitude ordering.
  - -0 equals +0.
  - +inf is greater than all finite values.
  - NaN operands always return 0.
- Latency, with the `start` edge as cycle 0:
  - `done` is high in cycle 3N+2.
  - For N = 0, `done` is high in cycle 2 with outputs at +inf / FFFF.
- Output timing:
  - Outputs change only on the DRAIN→DONE edge.
  - Outputs are stable while `done` = 1 and hold until the next scan completes.
- Handshake: `start` while `busy` = 1 is ignored and not queued. Inputs are sampled only at start.
- No table entries pass evaluation (all skipped): outputs are best_hop = FFFF, best_value = 7C00.

Decomposition:
- Shared package (`qroute_pkg`):
  - FP16_POS_INF = 16'h7C00
  - NO_HOP = 16'hFFFF
  - ENTRY_WORDS = 3
  - state encodings for IDLE / READ / DRAIN / DONE
  - WORD_WIDTH
- One sub-module: `fp16_less`, combinational (inputs a, b; output lt). It is reusable by the policy stage's comparisons.

Test Plan:
- N=3, base=0x010, entries (5, 0x4200, 7), (9, 0x3C00, 2), (12, 0x4000, 9); MY_NODE_ID=1; prev_hop=12 -> best_hop=9, best_value=0x3C00, best_origin=2, mybest=0x4000; `done` pulses exactly at cycle 11; `mem_addr` runs 0x010..0x018.
- Tie plus self-skip: entries (1, 0x3800, 0), (4, 0x3C00, 1), (6, 0x3C00, 2); MY_NODE_ID=1 -> best_hop=4, best_origin=1; prev_hop=20 (absent) -> mybest=0x7C00.
- NaN and signed zero: entries (3, 0x7E00, 0), (8, 0x8000, 5), (10, 0x0000, 6) -> best_hop=8, best_value=0x8000.
- N=0 -> no `mem_rd_en`; `done` at cycle 2; outputs FFFF / 7C00 / FFFF / 7C00.
- Busy-start and reset: `start` re-pulsed at cycle 4 of an N=3 scan -> ignored, single `done` at cycle 11. Separately, `nreset` low at cycle 5 -> all outputs at reset values next cycle, no `done`; a subsequent start gives a correct result.
- Wrap: base=0x3FE, N=1 -> reads 0x3FE, 0x3FF, 0x000; result is correct.
